// File: rtl/phys_reg_free_list_if.sv
// Rename / commit / recovery handshake bundle for the physical register free list.
interface phys_reg_free_list_if #(
  parameter int NUM_PHY_REGS  = 64,
  parameter int NUM_ARCH_REGS = 32
);
  localparam int PREG_W = $clog2(NUM_PHY_REGS);
  localparam int CNT_W  = $clog2(NUM_PHY_REGS - NUM_ARCH_REGS) + 1;

  logic              alloc_req;
  logic              alloc_ready;
  logic [PREG_W-1:0] alloc_preg;
  logic              release_valid;
  logic [PREG_W-1:0] release_preg;
  logic              commit_alloc;
  logic              flush;
  logic [CNT_W-1:0]  free_count;
  logic              init_done;
  logic              err;

  modport master (
    output alloc_req, release_valid, release_preg, commit_alloc, flush,
    input  alloc_ready, alloc_preg, free_count, init_done, err
  );

  modport slave (
    input  alloc_req, release_valid, release_preg, commit_alloc, flush,
    output alloc_ready, alloc_preg, free_count, init_done, err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register IDs with speculative head and commit-head rollback.
// Optional FREELIST_DEBUG_EN adds a free-bitmap mirror (double release / bad alloc -> err) and trace prints.
module phys_reg_free_list #(
  parameter int NUM_PHY_REGS  = 64,
  parameter int NUM_ARCH_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  phys_reg_free_list_if.slave   fl
);
  localparam int DEPTH  = NUM_PHY_REGS - NUM_ARCH_REGS;
  localparam int PREG_W = $clog2(NUM_PHY_REGS);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_RECOVER} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  commit_head_q, commit_head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  free_count_q, free_count_d;
  logic              init_done_q, init_done_d;
  logic              err_q, err_d, err_set;

  logic [PREG_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [PREG_W-1:0] mem_wdata;

  logic              alloc_ready_c;
  logic              do_alloc, rel_req, list_full, do_release;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      free_count_q  <= '0;
      init_done_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      free_count_q  <= free_count_d;
      init_done_q   <= init_done_d;
      err_q         <= err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[tail_q[IDX_W-1:0]] <= mem_wdata;
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    commit_head_d = commit_head_q;
    tail_d        = tail_q;
    free_count_d  = free_count_q;
    init_done_d   = init_done_q;
    err_d         = err_q;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    do_alloc      = 1'b0;
    rel_req       = 1'b0;
    list_full     = 1'b0;
    do_release    = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Tail doubles as the sweep counter: entry i holds NUM_ARCH_REGS+i.
        mem_we    = 1'b1;
        mem_wdata = PREG_W'(NUM_ARCH_REGS + int'(tail_q[IDX_W-1:0]));
        tail_d    = tail_q + 1'b1;
        if (tail_q == PTR_W'(DEPTH - 1)) begin
          state_d      = ST_RUN;
          free_count_d = PTR_W'(DEPTH);
          init_done_d  = 1'b1;
        end
      end
      default: begin
        do_alloc   = alloc_ready_c && fl.alloc_req && !fl.flush;
        rel_req    = fl.release_valid && (fl.release_preg != '0);
        // Full counts uncommitted allocations as occupied, not just the speculative window.
        list_full  = (PTR_W'(tail_q - commit_head_q) == PTR_W'(DEPTH));
        do_release = rel_req && !list_full;
        if (rel_req && list_full) err_d = 1'b1;
        if (do_release) begin
          mem_we    = 1'b1;
          mem_wdata = fl.release_preg;
          tail_d    = tail_q + 1'b1;
        end
        if (fl.commit_alloc) commit_head_d = commit_head_q + 1'b1;
        if (do_alloc) head_d = head_q + 1'b1;
        free_count_d = free_count_q + PTR_W'(do_release) - PTR_W'(do_alloc);
        if (fl.flush) begin
          head_d       = commit_head_d;
          free_count_d = tail_d - commit_head_d;
          state_d      = ST_RECOVER;
        end else begin
          state_d      = ST_RUN;
        end
      end
    endcase
  end

  // Output logic
  always_comb begin
    alloc_ready_c  = (state_q == ST_RUN) && (free_count_q != '0);
    fl.alloc_ready = alloc_ready_c;
    fl.alloc_preg  = (state_q == ST_INIT) ? '0 : mem[head_q[IDX_W-1:0]];
    fl.free_count  = free_count_q;
    fl.init_done   = init_done_q;
    fl.err         = err_q;
  end

`ifdef FREELIST_DEBUG_EN
  logic [NUM_PHY_REGS-1:0] free_map_q, free_map_d;
  logic                    dbg_err;
  logic [PTR_W-1:0]        dbg_ptr;
  logic [31:0]             cyc_q;

  always_comb begin
    free_map_d = free_map_q;
    dbg_err    = 1'b0;
    dbg_ptr    = '0;
    if (state_q == ST_INIT) begin
      free_map_d[mem_wdata] = 1'b1;
    end else begin
      if (rel_req && free_map_q[fl.release_preg]) dbg_err = 1'b1;
      if (do_alloc) begin
        if (!free_map_q[fl.alloc_preg]) dbg_err = 1'b1;
        free_map_d[fl.alloc_preg] = 1'b0;
      end
      if (do_release) free_map_d[fl.release_preg] = 1'b1;
      if (fl.flush) begin
        // Rebuild from the surviving window [commit_head, tail) plus this cycle's release.
        free_map_d = '0;
        for (int j = 0; j < DEPTH; j++) begin
          dbg_ptr = commit_head_d + PTR_W'(j);
          if (PTR_W'(j) < PTR_W'(tail_q - commit_head_d)) free_map_d[mem[dbg_ptr[IDX_W-1:0]]] = 1'b1;
        end
        if (do_release) free_map_d[fl.release_preg] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_map_q <= '0;
      cyc_q      <= '0;
    end else begin
      free_map_q <= free_map_d;
      cyc_q      <= cyc_q + 32'd1;
      if (do_alloc)   $display("%0d: ALLOC r%0d free=%0d", cyc_q, fl.alloc_preg, free_count_d);
      if (do_release) $display("%0d: RELEASE r%0d free=%0d", cyc_q, fl.release_preg, free_count_d);
      if (state_q != ST_INIT && fl.flush) $display("%0d: FLUSH free=%0d", cyc_q, free_count_d);
    end
  end

  assign err_set = err_d | dbg_err;
`else
  assign err_set = err_d;
`endif

  commit_not_past_head: assert property (@(posedge clk) disable iff (rst)
    (state_q != ST_INIT && fl.commit_alloc) |-> (commit_head_q != head_q));

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: vector table, directed corner sequences and a queue-model random run.
module tb_phys_reg_free_list;
  localparam int NPR   = 64;
  localparam int NAR   = 32;
  localparam int DEPTH = NPR - NAR;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  phys_reg_free_list_if #(.NUM_PHY_REGS(NPR), .NUM_ARCH_REGS(NAR)) fl_if ();

  phys_reg_free_list #(.NUM_PHY_REGS(NPR), .NUM_ARCH_REGS(NAR)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: lst holds every entry from commit head to tail, spec = uncommitted allocations.
  int m_state;
  int m_init_cnt;
  int lst[$];
  int spec;
  bit m_err;
  bit m_done;

  typedef struct {
    bit a; bit rv; int rp; bit c; bit f;
    bit er; int ep; int efc; bit eerr;
  } vec_t;
  vec_t vecs[13];

  function automatic void model_reset();
    m_state = 0; m_init_cnt = 0; lst.delete(); spec = 0; m_err = 0; m_done = 0;
  endfunction

  function automatic void model_step(bit a, bit rv, int rp, bit c, bit f);
    bit granted;
    bit full;
    if (m_state == 0) begin
      m_init_cnt++;
      if (m_init_cnt == DEPTH) begin
        for (int k = 0; k < DEPTH; k++) lst.push_back(NAR + k);
        m_state = 1;
        m_done  = 1;
      end
      return;
    end
    granted = (m_state == 1) && !f && a && (lst.size() - spec > 0);
    full    = (lst.size() == DEPTH);
    if (rv && rp != 0) begin
      if (full) m_err = 1;
      else lst.push_back(rp);
    end
    if (c) begin
      void'(lst.pop_front());
      spec--;
    end
    if (granted) spec++;
    if (f) begin
      spec = 0;
      m_state = 2;
    end else begin
      m_state = 1;
    end
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    fl_if.alloc_req = 1'b0; fl_if.release_valid = 1'b0; fl_if.release_preg = '0;
    fl_if.commit_alloc = 1'b0; fl_if.flush = 1'b0;
  endtask

  task automatic tick(input bit a, input bit rv, input int rp, input bit c, input bit f);
    fl_if.alloc_req = a; fl_if.release_valid = rv; fl_if.release_preg = 6'(rp);
    fl_if.commit_alloc = c; fl_if.flush = f;
    model_step(a, rv, rp, c, f);
    @(posedge clk);
    #1;
    clear_inputs();
    $display("t=%0t a=%0d rv=%0d rp=r%0d c=%0d f=%0d | ready=%0d preg=r%0d fc=%0d done=%0d err=%0d",
             $time, a, rv, rp, c, f, fl_if.alloc_ready, fl_if.alloc_preg, fl_if.free_count,
             fl_if.init_done, fl_if.err);
  endtask

  task automatic check_model(input string tag);
    int fc;
    bit rdy;
    fc  = (m_state == 0) ? 0 : lst.size() - spec;
    rdy = (m_state == 1) && (fc > 0);
    check({tag, "_ready"}, int'(fl_if.alloc_ready), int'(rdy));
    check({tag, "_fc"}, int'(fl_if.free_count), fc);
    check({tag, "_err"}, int'(fl_if.err), int'(m_err));
    check({tag, "_done"}, int'(fl_if.init_done), int'(m_done));
    if (rdy) check({tag, "_preg"}, int'(fl_if.alloc_preg), lst[spec]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, int'(fl_if.alloc_ready), 0);
    check({tag, "_preg"}, int'(fl_if.alloc_preg), 0);
    check({tag, "_fc"}, int'(fl_if.free_count), 0);
    check({tag, "_done"}, int'(fl_if.init_done), 0);
    check({tag, "_err"}, int'(fl_if.err), 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (DEPTH) tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    clear_inputs();
    // Fixed vectors applied right after the first INIT sweep.
    vecs[0]  = '{1, 0, 0, 0, 0, 1, 33, 31, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 1, 34, 30, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 1, 35, 29, 0};
    vecs[3]  = '{0, 0, 0, 1, 0, 1, 35, 29, 0};
    vecs[4]  = '{0, 0, 0, 0, 1, 0, -1, 31, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 1, 33, 31, 0};
    vecs[6]  = '{1, 1, 5, 0, 0, 1, 34, 31, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 1, 34, 31, 0};
    vecs[8]  = '{0, 0, 0, 1, 1, 0, -1, 31, 0};
    vecs[9]  = '{0, 1, 6, 0, 1, 0, -1, 32, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 1, 34, 32, 0};
    vecs[11] = '{0, 1, 7, 0, 0, 1, 34, 32, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 1, 34, 32, 1};

    // Reset values, then INIT sweep with every request input held active (all ignored).
    #1 rst = 1'b1;
    #1 check_reset_vals("rst");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (DEPTH - 1) tick(1, 1, 9, 1, 1);
    check("init31_done", int'(fl_if.init_done), 0);
    check("init31_fc", int'(fl_if.free_count), 0);
    check("init31_ready", int'(fl_if.alloc_ready), 0);
    tick(1, 1, 9, 1, 1);
    check("init32_done", int'(fl_if.init_done), 1);
    check("init32_fc", int'(fl_if.free_count), 32);
    check("init32_ready", int'(fl_if.alloc_ready), 1);
    check("init32_preg", int'(fl_if.alloc_preg), 32);
    check("init32_err", int'(fl_if.err), 0);

    for (int i = 0; i < 13; i++) begin
      tick(vecs[i].a, vecs[i].rv, vecs[i].rp, vecs[i].c, vecs[i].f);
      check($sformatf("vec%0d_ready", i), int'(fl_if.alloc_ready), int'(vecs[i].er));
      check($sformatf("vec%0d_fc", i), int'(fl_if.free_count), vecs[i].efc);
      check($sformatf("vec%0d_err", i), int'(fl_if.err), int'(vecs[i].eerr));
      if (vecs[i].er) check($sformatf("vec%0d_preg", i), int'(fl_if.alloc_preg), vecs[i].ep);
    end

    // Drain all 32, commit two, then refill paths with no same-cycle bypass.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d_preg", i), int'(fl_if.alloc_preg), 32 + i);
      check($sformatf("drain%0d_ready", i), int'(fl_if.alloc_ready), 1);
      tick(1, 0, 0, 0, 0);
    end
    check("empty_ready", int'(fl_if.alloc_ready), 0);
    check("empty_fc", int'(fl_if.free_count), 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 1, 5, 0, 0);
    check("rel5_ready", int'(fl_if.alloc_ready), 1);
    check("rel5_preg", int'(fl_if.alloc_preg), 5);
    check("rel5_fc", int'(fl_if.free_count), 1);
    tick(1, 0, 0, 0, 0);
    check("take5_ready", int'(fl_if.alloc_ready), 0);
    check("take5_fc", int'(fl_if.free_count), 0);
    tick(1, 1, 7, 0, 0);
    check("nobypass_fc", int'(fl_if.free_count), 1);
    check("nobypass_ready", int'(fl_if.alloc_ready), 1);
    check("nobypass_preg", int'(fl_if.alloc_preg), 7);
    check("nobypass_err", int'(fl_if.err), 0);

    // Overflow on a truly full list, then asynchronous reset in the middle of allocations.
    do_reset();
    tick(0, 1, 10, 0, 0);
    check("ovf_err", int'(fl_if.err), 1);
    check("ovf_fc", int'(fl_if.free_count), 32);
    check("ovf_preg", int'(fl_if.alloc_preg), 32);
    repeat (5) tick(1, 0, 0, 0, 0);
    check("ovf_sticky", int'(fl_if.err), 1);
    check("mid_fc", int'(fl_if.free_count), 27);
    fl_if.alloc_req = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_vals("async");
    @(posedge clk);
    #1 rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (DEPTH - 1) tick(0, 0, 0, 0, 0);
    check("reinit31_fc", int'(fl_if.free_count), 0);
    tick(0, 0, 0, 0, 0);
    check("reinit32_fc", int'(fl_if.free_count), 32);
    check("reinit32_preg", int'(fl_if.alloc_preg), 32);

    // Random traffic against the queue model.
    do_reset();
    check_model("rnd_start");
    for (int n = 0; n < 400; n++) begin
      bit a, rv, c, f;
      int rp;
      a  = ($urandom % 10) < 6;
      c  = (spec > 0) && (($urandom % 3) == 0);
      f  = ($urandom % 20) == 0;
      rv = ($urandom % 10) < 4;
      if (lst.size() == DEPTH && ($urandom % 10) != 0) rv = 1'b0;
      rp = int'($urandom % 64);
      tick(a, rv, rp, c, f);
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
